// File: rtl/can_tx_dom_guard.sv
// CAN TX dominant-timeout guard with registered TX pass-through and 2-FF RX synchroniser.
// Optional build macro CAN_TX_GUARD_AUTO_REL_EN: leave TRIPPED without software fault_clr.
//
// state    | meaning
// ---------+------------------------------------------------------------
// PASS     | TX forwarded with one cycle latency, dominant run length timed
// TRIPPED  | TX forced recessive, fault latched, waiting for fault_clr
// RELEASE  | TX forced recessive, waiting for REL_CYCLES of recessive input
module can_tx_dom_guard #(
  parameter int DOM_LIMIT  = 20000,
  parameter int REL_CYCLES = 550
) (
  input  logic       FAB_CCC_GL0,
  input  logic       FAB_RESET_N,
  input  logic       can_tx_in,
  input  logic       can_tx_en_n_in,
  input  logic       can_rx_pin,
  input  logic       fault_clr,
  output logic       can_tx_pin,
  output logic       can_rx_out,
  output logic       fault,
  output logic [7:0] trip_count
);

  localparam int DW = $clog2(DOM_LIMIT + 1);
  localparam int RW = $clog2(REL_CYCLES + 1);
  localparam logic [DW-1:0] DOM_LAST = DW'(DOM_LIMIT - 1);
  localparam logic [RW-1:0] REL_LAST = RW'(REL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PASS    = 2'd0,
    ST_TRIPPED = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] dom_cnt, dom_cnt_nxt;
  logic [RW-1:0] rel_cnt, rel_cnt_nxt;
  logic          tx_pin_nxt;
  logic          fault_nxt;
  logic [7:0]    trip_nxt;
  logic          rx_meta;
  logic          tx_dom;
  logic          clr_req;

  assign tx_dom = ~can_tx_in & ~can_tx_en_n_in;

`ifdef CAN_TX_GUARD_AUTO_REL_EN
  // Recovery is autonomous, so the software clear is deliberately ignored.
  logic clr_unused;
  assign clr_unused = fault_clr;
  assign clr_req    = 1'b1;
`else
  assign clr_req    = fault_clr;
`endif

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) state <= ST_PASS;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    dom_cnt_nxt = dom_cnt;
    rel_cnt_nxt = rel_cnt;
    tx_pin_nxt  = 1'b1;
    fault_nxt   = fault;
    trip_nxt    = trip_count;
    case (state)
      ST_PASS: begin
        tx_pin_nxt = ~tx_dom;
        if (!tx_dom) begin
          dom_cnt_nxt = '0;
        end else if (dom_cnt == DOM_LAST) begin
          // The tripping cycle is still driven dominant: the bus sees exactly DOM_LIMIT cycles.
          state_nxt   = ST_TRIPPED;
          fault_nxt   = 1'b1;
          dom_cnt_nxt = '0;
          if (trip_count != 8'hFF) trip_nxt = trip_count + 8'd1;
        end else begin
          dom_cnt_nxt = dom_cnt + 1'b1;
        end
      end
      ST_TRIPPED: begin
        if (clr_req) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (tx_dom) begin
          rel_cnt_nxt = '0;
        end else if (rel_cnt == REL_LAST) begin
          state_nxt   = ST_PASS;
          fault_nxt   = 1'b0;
          rel_cnt_nxt = '0;
        end else begin
          rel_cnt_nxt = rel_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_PASS;
      end
    endcase
  end

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      dom_cnt    <= '0;
      rel_cnt    <= '0;
      can_tx_pin <= 1'b1;
      fault      <= 1'b0;
      trip_count <= 8'd0;
    end else begin
      dom_cnt    <= dom_cnt_nxt;
      rel_cnt    <= rel_cnt_nxt;
      can_tx_pin <= tx_pin_nxt;
      fault      <= fault_nxt;
      trip_count <= trip_nxt;
    end
  end

  // RX path is independent of the guard; idle bus level is recessive.
  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      rx_meta    <= 1'b1;
      can_rx_out <= 1'b1;
    end else begin
      rx_meta    <= can_rx_pin;
      can_rx_out <= rx_meta;
    end
  end

endmodule
